potential_accumulator: RTL and testbench
========================================

POTENTIAL_ACCUMULATOR -- requirements
Module: potential_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the spike counter.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port en, input, 1, enable for accumulation and step processing.
REQ-005 SHALL have port cfg_we, input, 1, config write strobe.
REQ-006 SHALL have port cfg_threshold, input, 32, signed firing threshold, latched on cfg_we.
REQ-007 SHALL have port cfg_v_reset, input, 32, signed post-spike potential, latched on cfg_we.
REQ-008 SHALL have port w_valid, input, 1, synaptic weight valid.
REQ-009 SHALL have port w_data, input, 32, signed synaptic weight.
REQ-010 SHALL have port w_ready, output, 1, weight accept.
REQ-011 SHALL have port time_step, input, 1, step strobe; rising-edge detected.
REQ-012 SHALL have port decay_potential, input, 32, decayed membrane potential from the decay stage.
REQ-013 SHALL have port decay_load, output, 1, load pulse to the decay stage.
REQ-014 SHALL have port new_potential, output, 32, potential written back to the decay stage.
REQ-015 SHALL have port spike, output, 1, one-cycle spike pulse.
REQ-016 SHALL have port potential, output, 32, last integrated potential, pre-reset.
REQ-017 SHALL have port spike_count, output, CNT_W, spike counter.
REQ-018 SHALL have port overrun, output, 1, sticky missed-step flag.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, CHECK, LOAD, HOLD.
REQ-020 SHALL leave IDLE for ACCUM on the edge where en=1, and SHALL remain in IDLE while en=0.
REQ-021 SHALL drive w_ready=1 only in ACCUM.
REQ-022 SHALL, on each w_valid&&w_ready, set syn <= sat32(syn + w_data), where sat32 clamps signed results to 0x7FFFFFFF / 0x80000000.
REQ-023 SHALL register prev_ts each cycle and treat time_step && !prev_ts as a step event.
REQ-024 SHALL, on a step event in ACCUM, go to CHECK at that edge (edge E0); a weight accepted on E0 is included in syn.
REQ-025 SHALL, in CHECK (edge E1), compute v = sat32(decay_potential + syn) and set potential <= v.
REQ-026 SHALL, in CHECK, apply the firing rule: if v >= threshold (signed), set spike <= 1, new_potential <= v_reset, and spike_count <= spike_count + 1; otherwise set new_potential <= v.
REQ-027 SHALL, in CHECK, clear syn to 0 and go to LOAD.
REQ-028 SHALL wrap spike_count from all-ones to 0 without error.
REQ-029 SHALL deassert spike after exactly one cycle.
REQ-030 SHALL, in LOAD (edge E2), set decay_load <= 1 and go to HOLD.
REQ-031 SHALL, in HOLD (edge E3), set decay_load <= 0, giving a one-cycle decay_load pulse with new_potential stable throughout it.
REQ-032 SHALL, from HOLD, go to ACCUM if en=1, else to IDLE.
REQ-033 SHALL ignore a step event in CHECK, LOAD or HOLD and SHALL set overrun=1 (sticky until rst).
REQ-034 SHALL ignore a step event in IDLE, with no overrun.
REQ-035 SHALL, on en deassertion during CHECK, LOAD or HOLD, complete the sequence and then go to IDLE; syn SHALL be retained across IDLE.
REQ-036 SHALL, on cfg_we, register threshold and v_reset in any state; a write on E1 SHALL NOT affect that CHECK.

Reset
REQ-037 SHALL, on rst=1 at any edge, including mid-sequence, set state=IDLE, syn=0, prev_ts=0, threshold=0x00000100, v_reset=0.
REQ-038 SHALL, on the same reset, set spike=0, decay_load=0, new_potential=0, potential=0, spike_count=0, overrun=0, w_ready=0.
REQ-039 SHALL give rst priority over all other inputs.

Verification
REQ-040 SHALL cover: threshold=100, weights 30, 20, decay_potential=40, step -> no spike, potential=new_potential=90, one decay_load pulse at E2.
REQ-041 SHALL cover: the next step with decay_potential=45 and weight 60 -> spike for one cycle after E1, potential=105, new_potential=v_reset=0, spike_count=1.
REQ-042 SHALL cover: weights 0x7FFFFFF0 and 0x20 with decay_potential=0 -> potential=0x7FFFFFFF; weights -0x7FFFFFFF and -0x10 -> 0x80000000.
REQ-043 SHALL cover: a second time_step rise during LOAD -> ignored, overrun=1, FSM returns to ACCUM, next valid step processed normally.
REQ-044 SHALL cover: rst asserted in CHECK -> next cycle all outputs at reset values, no decay_load pulse.

Source files
------------

// File: rtl/potential_accumulator.sv
// rtl/potential_accumulator.sv - integrate-and-fire membrane potential accumulator
module potential_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [31:0]      cfg_threshold,
  input  logic [31:0]      cfg_v_reset,
  input  logic             w_valid,
  input  logic [31:0]      w_data,
  output logic             w_ready,
  input  logic             time_step,
  input  logic [31:0]      decay_potential,
  output logic             decay_load,
  output logic [31:0]      new_potential,
  output logic             spike,
  output logic [31:0]      potential,
  output logic [CNT_W-1:0] spike_count,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, ACCUM, CHECK, LOAD, HOLD} state_t;

  state_t             state, state_nxt;
  logic signed [31:0] syn;
  logic signed [31:0] threshold;
  logic signed [31:0] v_reset;
  logic signed [31:0] v;
  logic               prev_ts;
  logic               step_evt;
  logic               w_fire;
  logic               fire;

  // Signed add clamped to the 32-bit range instead of wrapping.
  function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      sat32 = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      sat32 = s[31:0];
  endfunction

  assign w_ready  = (state == ACCUM);
  assign w_fire   = w_valid && w_ready;
  assign step_evt = time_step && !prev_ts;
  assign v        = sat32(decay_potential, syn);
  assign fire     = (v >= threshold);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en) state_nxt = ACCUM;
      ACCUM: begin
        if (!en)           state_nxt = IDLE;
        else if (step_evt) state_nxt = CHECK;
      end
      CHECK: state_nxt = LOAD;
      LOAD:  state_nxt = HOLD;
      HOLD:  state_nxt = en ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syn           <= '0;
      prev_ts       <= 1'b0;
      threshold     <= 32'sh0000_0100;
      v_reset       <= '0;
      spike         <= 1'b0;
      decay_load    <= 1'b0;
      new_potential <= '0;
      potential     <= '0;
      spike_count   <= '0;
      overrun       <= 1'b0;
    end else begin
      prev_ts <= time_step;
      spike   <= 1'b0;
      // CHECK reads the pre-write threshold/v_reset, so a write on that edge applies next time.
      if (cfg_we) begin
        threshold <= cfg_threshold;
        v_reset   <= cfg_v_reset;
      end
      if (state == CHECK)
        syn <= '0;
      else if (w_fire)
        syn <= sat32(syn, w_data);
      if (step_evt && (state == CHECK || state == LOAD || state == HOLD))
        overrun <= 1'b1;
      case (state)
        CHECK: begin
          potential <= v;
          if (fire) begin
            spike         <= 1'b1;
            new_potential <= v_reset;
            spike_count   <= spike_count + CNT_W'(1);
          end else begin
            new_potential <= v;
          end
        end
        LOAD:    decay_load <= 1'b1;
        HOLD:    decay_load <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_potential_accumulator.sv
// tb/tb_potential_accumulator.sv - directed self-checking bench for potential_accumulator
module tb_potential_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_we;
  logic [31:0] cfg_threshold;
  logic [31:0] cfg_v_reset;
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_ready;
  logic        time_step;
  logic [31:0] decay_potential;
  logic        decay_load;
  logic [31:0] new_potential;
  logic        spike;
  logic [31:0] potential;
  logic [1:0]  spike_count;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  potential_accumulator #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we),
    .cfg_threshold(cfg_threshold), .cfg_v_reset(cfg_v_reset),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .time_step(time_step), .decay_potential(decay_potential),
    .decay_load(decay_load), .new_potential(new_potential),
    .spike(spike), .potential(potential), .spike_count(spike_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [31:0] d);
    w_valid = 1'b1;
    w_data  = d;
    cyc();
    w_valid = 1'b0;
  endtask

  // Step edge E0 followed by E1..E3 of the update sequence.
  task automatic full_step(input logic [31:0] dp);
    decay_potential = dp;
    time_step = 1'b1;
    cyc();
    time_step = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_threshold = '0; cfg_v_reset = '0;
    w_valid = 1'b0; w_data = '0; time_step = 1'b0; decay_potential = '0;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_spike", 32'(spike), 32'd0);
    check("rst_decay_load", 32'(decay_load), 32'd0);
    check("rst_new_potential", new_potential, 32'd0);
    check("rst_potential", potential, 32'd0);
    check("rst_spike_count", 32'(spike_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd0);

    // Default threshold 0x100: 0xFF stays below, 0x100 fires.
    en = 1'b1;
    cyc();
    check("accum_w_ready", 32'(w_ready), 32'd1);
    send_w(32'd255);
    full_step(32'd0);
    check("dflt_thr_below", potential, 32'd255);
    check("dflt_thr_below_cnt", 32'(spike_count), 32'd0);
    send_w(32'd256);
    full_step(32'd0);
    check("dflt_thr_equal_cnt", 32'(spike_count), 32'd1);

    // Reset again to start the spec scenarios from zero counts.
    rst = 1'b1; cyc(); rst = 1'b0;
    cfg_we = 1'b1; cfg_threshold = 32'd100; cfg_v_reset = 32'd0;
    cyc();
    cfg_we = 1'b0;
    cyc();

    // 30 + 20 + 40 = 90 < 100
    send_w(32'd30);
    send_w(32'd20);
    decay_potential = 32'd40;
    time_step = 1'b1;
    cyc();
    time_step = 1'b0;
    check("check_w_ready", 32'(w_ready), 32'd0);
    check("e0_decay_load", 32'(decay_load), 32'd0);
    cyc();
    check("t1_potential", potential, 32'd90);
    check("t1_new_potential", new_potential, 32'd90);
    check("t1_spike", 32'(spike), 32'd0);
    check("t1_e1_decay_load", 32'(decay_load), 32'd0);
    cyc();
    check("t1_e2_decay_load", 32'(decay_load), 32'd1);
    cyc();
    check("t1_e3_decay_load", 32'(decay_load), 32'd0);
    check("t1_back_accum", 32'(w_ready), 32'd1);

    // 60 accepted on E0 itself + 45 = 105 >= 100
    decay_potential = 32'd45;
    w_valid = 1'b1; w_data = 32'd60; time_step = 1'b1;
    cyc();
    w_valid = 1'b0; time_step = 1'b0;
    cyc();
    check("t2_spike", 32'(spike), 32'd1);
    check("t2_potential", potential, 32'd105);
    check("t2_new_potential", new_potential, 32'd0);
    check("t2_spike_count", 32'(spike_count), 32'd1);
    cyc();
    check("t2_spike_one_cycle", 32'(spike), 32'd0);
    check("t2_e2_decay_load", 32'(decay_load), 32'd1);
    cyc();

    // Positive and negative saturation
    send_w(32'h7FFF_FFF0);
    send_w(32'h0000_0020);
    full_step(32'd0);
    check("sat_pos_potential", potential, 32'h7FFF_FFFF);
    check("sat_pos_count", 32'(spike_count), 32'd2);
    send_w(32'h8000_0001);
    send_w(32'hFFFF_FFF0);
    full_step(32'd0);
    check("sat_neg_potential", potential, 32'h8000_0000);
    check("sat_neg_new_potential", new_potential, 32'h8000_0000);
    check("sat_neg_count", 32'(spike_count), 32'd2);

    // syn retained across IDLE; step in IDLE ignored without overrun
    send_w(32'd5);
    en = 1'b0;
    cyc();
    check("idle_w_ready", 32'(w_ready), 32'd0);
    time_step = 1'b1; cyc(); time_step = 1'b0; cyc();
    check("idle_step_no_overrun", 32'(overrun), 32'd0);
    check("idle_step_no_load", 32'(decay_load), 32'd0);
    check("idle_step_no_potential", potential, 32'h8000_0000);
    en = 1'b1;
    cyc();
    send_w(32'd95);
    decay_potential = 32'd0;
    time_step = 1'b1;
    cyc();
    time_step = 1'b0;
    // Config write on E1 must not affect this CHECK
    cfg_we = 1'b1; cfg_threshold = 32'd1000; cfg_v_reset = 32'd7;
    cyc();
    cfg_we = 1'b0;
    check("retain_potential", potential, 32'd100);
    check("cfg_e1_spike", 32'(spike), 32'd1);
    check("cfg_e1_new_potential", new_potential, 32'd0);
    cyc(); cyc();
    cfg_we = 1'b1; cfg_threshold = 32'd100; cfg_v_reset = 32'd0;
    cyc();
    cfg_we = 1'b0;

    // Second step rise during LOAD
    send_w(32'd10);
    decay_potential = 32'd0;
    time_step = 1'b1; cyc(); time_step = 1'b0;
    cyc();
    time_step = 1'b1;
    cyc();
    time_step = 1'b0;
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_decay_load", 32'(decay_load), 32'd1);
    cyc();
    check("ovr_back_accum", 32'(w_ready), 32'd1);
    check("ovr_pulse_end", 32'(decay_load), 32'd0);
    check("ovr_potential", potential, 32'd10);
    send_w(32'd200);
    time_step = 1'b1; cyc(); time_step = 1'b0;
    cyc();
    check("ovr_next_spike", 32'(spike), 32'd1);
    check("ovr_next_potential", potential, 32'd200);
    check("count_wrap", 32'(spike_count), 32'd0);
    cyc(); cyc();
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in CHECK
    send_w(32'd500);
    time_step = 1'b1; cyc(); time_step = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rc_spike", 32'(spike), 32'd0);
    check("rc_potential", potential, 32'd0);
    check("rc_new_potential", new_potential, 32'd0);
    check("rc_spike_count", 32'(spike_count), 32'd0);
    check("rc_overrun", 32'(overrun), 32'd0);
    check("rc_w_ready", 32'(w_ready), 32'd0);
    check("rc_decay_load", 32'(decay_load), 32'd0);
    cyc();
    check("rc_no_load_1", 32'(decay_load), 32'd0);
    cyc();
    check("rc_no_load_2", 32'(decay_load), 32'd0);
    check("rc_potential_hold", potential, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
